// File: rtl/ddr2_line_fetch.sv
// Frame line fetcher: requests one line per row from ddr2_mgr and streams the returned words.
// Latency: a returned word is visible on out_* one cycle after the edge that captured it.
// Backpressure: out_ready stalls the FIFO; a new line is requested only when a whole line fits.
module ddr2_line_fetch #(
  parameter int          ROW_W      = 13,
  parameter int          COL_W      = 10,
  parameter int          BANK_W     = 2,
  parameter int unsigned LINE_WORDS = 'h200,
  parameter int unsigned MAX_ROW    = 'h2FF,
  parameter int          FIFO_AW    = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run_en,
  output logic                          rd_mem_req,
  output logic [ROW_W+COL_W+BANK_W-1:0] rd_mem_addr,
  output logic [9:0]                    rd_xfr_len,
  input  logic                          rd_mem_grant,
  input  logic [31:0]                   rd_data,
  input  logic                          rd_data_valid,
  output logic [31:0]                   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sol,
  output logic                          out_eof,
  output logic                          busy,
  output logic [15:0]                   frame_cnt,
  output logic                          err_ovf,
  output logic                          err_extra
);

  localparam int ADDR_W = ROW_W + COL_W + BANK_W;
  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int CW     = FIFO_AW + 1;

  localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0]    LW_C      = CW'(LINE_WORDS);
  localparam logic [10:0]      LW_M1     = 11'(LINE_WORDS - 1);
  localparam logic [9:0]       LEN_C     = 10'(LINE_WORDS);
  localparam logic [ROW_W-1:0] MAX_ROW_C = ROW_W'(MAX_ROW);
  localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_GRANT,
    S_XFR,
    S_LINE_DONE
  } state_t;

  state_t              state_q;
  logic [ROW_W-1:0]    row_q;
  logic [10:0]         wcnt_q;
  logic                req_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [9:0]          len_q;
  logic [15:0]         frame_q;
  logic                err_ovf_q;
  logic                err_extra_q;

  // FIFO: memory plus a head register so a pushed word appears one cycle later
  logic [33:0]         mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q;
  logic [FIFO_AW-1:0]  rd_ptr_q;
  logic [CW-1:0]       mem_cnt_q;
  logic                head_vld_q;
  logic [33:0]         head_q;

  logic [CW-1:0]       fill;
  logic [CW-1:0]       fill_d;
  logic                full;
  logic                pop;
  logic                push;
  logic                push_acc;
  logic                load;
  logic                sol_tag;
  logic                eof_tag;
  logic [33:0]         push_dat;
  logic                free_ok;

  assign pop      = head_vld_q & out_ready;
  assign push     = (state_q == S_XFR) & rd_data_valid;
  assign fill     = mem_cnt_q + {{FIFO_AW{1'b0}}, head_vld_q};
  assign full     = (fill == DEPTH_C);
  // a pop in the same cycle makes room, so a push into a full FIFO is still taken
  assign push_acc = push & (~full | pop);
  assign load     = (mem_cnt_q != '0) & (~head_vld_q | pop);
  assign fill_d   = fill + {{FIFO_AW{1'b0}}, push_acc} - {{FIFO_AW{1'b0}}, pop};
  assign free_ok  = (DEPTH_C - fill_d) >= LW_C;

  assign sol_tag  = (wcnt_q == 11'd0);
  assign eof_tag  = (wcnt_q == LW_M1) && (row_q == MAX_ROW_C);
  assign push_dat = {sol_tag, eof_tag, rd_data};

  // FIFO storage write (no reset needed: occupancy is tracked by the counters)
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr_q] <= push_dat;
  end

  // FIFO pointers, occupancy and head register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      head_vld_q <= 1'b0;
      head_q     <= '0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (load)     rd_ptr_q <= rd_ptr_q + 1'b1;
      mem_cnt_q <= mem_cnt_q + {{FIFO_AW{1'b0}}, push_acc} - {{FIFO_AW{1'b0}}, load};
      if (load) begin
        head_q     <= mem[rd_ptr_q];
        head_vld_q <= 1'b1;
      end else if (pop) begin
        head_vld_q <= 1'b0;
      end
    end
  end

  // Line request FSM with registered request, address and length outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      wcnt_q  <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      frame_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_en && free_ok) begin
            state_q <= S_WAIT_GRANT;
            req_q   <= 1'b1;
            addr_q  <= {row_q, {COL_W{1'b0}}, {BANK_W{1'b0}}};
            len_q   <= LEN_C;
          end
        end
        S_WAIT_GRANT: begin
          // run_en is deliberately ignored here: an issued request is always completed
          if (rd_mem_grant) begin
            state_q <= S_XFR;
            req_q   <= 1'b0;
            wcnt_q  <= '0;
          end
        end
        S_XFR: begin
          if (rd_data_valid) begin
            wcnt_q <= wcnt_q + 11'd1;
            if (wcnt_q == LW_M1) state_q <= S_LINE_DONE;
          end
        end
        S_LINE_DONE: begin
          if (row_q == MAX_ROW_C) begin
            row_q   <= '0;
            frame_q <= frame_q + 16'd1;
          end else begin
            row_q <= row_q + ROW_ONE;
          end
          len_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Sticky protocol error flags, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf_q   <= 1'b0;
      err_extra_q <= 1'b0;
    end else begin
      if (push && !push_acc) err_ovf_q <= 1'b1;
      if (rd_data_valid && (state_q == S_IDLE || state_q == S_WAIT_GRANT)) err_extra_q <= 1'b1;
    end
  end

  assign rd_mem_req  = req_q;
  assign rd_mem_addr = addr_q;
  assign rd_xfr_len  = len_q;
  assign out_data    = head_q[31:0];
  assign out_valid   = head_vld_q;
  assign out_sol     = head_vld_q & head_q[33];
  assign out_eof     = head_vld_q & head_q[32];
  assign busy        = (state_q != S_IDLE);
  assign frame_cnt   = frame_q;
  assign err_ovf     = err_ovf_q;
  assign err_extra   = err_extra_q;

endmodule

// File: tb/tb_ddr2_line_fetch.sv
// Bench for ddr2_line_fetch with a scaled-down line/frame so full frames fit in a short run.
// A queue-based model predicts every output each cycle; directed literals pin key points.
module tb_ddr2_line_fetch;

  localparam int LW    = 8;
  localparam int FAW   = 4;
  localparam int DEPTH = 16;
  localparam int MAXR  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_en = 1'b0;
  logic        grant = 1'b0;
  logic        dvld = 1'b0;
  logic [31:0] dat = '0;
  logic        out_ready = 1'b0;

  logic        rd_mem_req;
  logic [24:0] rd_mem_addr;
  logic [9:0]  rd_xfr_len;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_sol;
  logic        out_eof;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        err_ovf;
  logic        err_extra;

  ddr2_line_fetch #(.LINE_WORDS(LW), .MAX_ROW(MAXR), .FIFO_AW(FAW)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en),
    .rd_mem_req(rd_mem_req), .rd_mem_addr(rd_mem_addr), .rd_xfr_len(rd_xfr_len),
    .rd_mem_grant(grant), .rd_data(dat), .rd_data_valid(dvld),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sol(out_sol), .out_eof(out_eof), .busy(busy), .frame_cnt(frame_cnt),
    .err_ovf(err_ovf), .err_extra(err_extra)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [33:0] w;   // {sol, eof, data}
    int          t;   // edge index at which the word entered the FIFO
  } ent_t;

  ent_t        mq[$];
  int          cyc = 0;
  int          mph = 0;       // 0 idle, 1 waiting for grant, 2 receiving, 3 line done
  bit          m_req = 0;
  logic [24:0] m_addr = '0;
  logic [9:0]  m_len = '0;
  int          m_row = 0;
  int          m_got = 0;
  logic [15:0] m_frames = '0;
  bit          m_ovf = 0;
  bit          m_extra = 0;
  bit          force_full = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mph = 0; m_req = 0; m_addr = '0; m_len = '0; m_row = 0; m_got = 0;
      m_frames = '0; m_ovf = 0; m_extra = 0;
    end else begin
      bit   hv;
      bit   pop_m;
      bit   was_full;
      int   fill;
      ent_t e;
      hv       = (mq.size() > 0) && (mq[0].t < cyc);
      was_full = force_full || (mq.size() >= DEPTH);
      cyc++;
      pop_m = hv && out_ready;
      if (pop_m) void'(mq.pop_front());
      fill = mq.size();
      case (mph)
        0: begin
          if (dvld) m_extra = 1;
          if (run_en && (DEPTH - fill) >= LW) begin
            mph = 1; m_req = 1; m_addr = 25'(m_row) << 12; m_len = 10'(LW);
          end
        end
        1: begin
          if (dvld) m_extra = 1;
          if (grant) begin mph = 2; m_req = 0; m_got = 0; end
        end
        2: begin
          if (dvld) begin
            e.w = {(m_got == 0), (m_got == LW - 1 && m_row == MAXR), dat};
            e.t = cyc;
            if (was_full && !pop_m) m_ovf = 1;
            else mq.push_back(e);
            m_got++;
            if (m_got == LW) mph = 3;
          end
        end
        default: begin
          if (m_row == MAXR) begin m_row = 0; m_frames = m_frames + 16'd1; end
          else m_row = m_row + 1;
          m_len = '0;
          mph = 0;
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  int pops = 0;
  int eofs = 0;
  int reqs = 0;
  bit req_prev = 0;

  always @(negedge clk) begin
    bit hv;
    hv = (mq.size() > 0) && (mq[0].t < cyc);
    chk("req", rd_mem_req, m_req);
    chk("addr", rd_mem_addr, m_addr);
    chk("xfr_len", rd_xfr_len, m_len);
    chk("busy", busy, mph != 0);
    chk("frame_cnt", frame_cnt, m_frames);
    chk("err_ovf", err_ovf, m_ovf);
    chk("err_extra", err_extra, m_extra);
    chk("out_valid", out_valid, hv);
    if (hv) begin
      chk("out_data", out_data, mq[0].w[31:0]);
      chk("out_sol", out_sol, mq[0].w[33]);
      chk("out_eof", out_eof, mq[0].w[32]);
    end
    if (out_valid && out_ready) begin
      pops++;
      if (out_eof) eofs++;
    end
    if (rd_mem_req && !req_prev) reqs++;
    req_prev = rd_mem_req;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_req();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (rd_mem_req) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("wait_req_timeout", ok, 1'b1);
  endtask

  task automatic grant_after(input int d);
    tick(d);
    grant = 1'b1;
    tick();
    grant = 1'b0;
  endtask

  task automatic send(input int n, input int off, input int base);
    for (int i = 0; i < n; i++) begin
      dvld = 1'b1;
      dat  = 32'(base + i);
      tick();
      dvld = 1'b0;
      if (off > 0) tick(off);
    end
    dvld = 1'b0;
  endtask

  initial begin
    int p0;
    // reset values
    rst_n = 1'b0;
    tick(2);
    chk("rst_req", rd_mem_req, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame", frame_cnt, 16'h0);
    rst_n = 1'b1;

    // 1: first line, contiguous data, grant after 3 cycles
    run_en = 1'b1; out_ready = 1'b1;
    wait_req();
    chk("t1_addr", rd_mem_addr, 25'h0000000);
    chk("t1_len", rd_xfr_len, 10'd8);
    grant_after(3);
    send(LW, 0, 0);
    wait_req();
    chk("t1_next_addr", rd_mem_addr, 25'h0001000);
    chk("t1_pops", pops, 8);

    // 2: gapped valid 1-on/2-off; line must not end before the last word
    grant_after(3);
    send(LW - 1, 2, 100);
    tick(3);
    chk("t2_busy_before_last", busy, 1'b1);
    send(1, 0, 107);
    wait_req();
    chk("t2_next_addr", rd_mem_addr, 25'h0002000);
    chk("t2_no_ovf", err_ovf, 1'b0);
    chk("t2_no_extra", err_extra, 1'b0);

    // 3 + 4: stalled consumer; rows 2 and 3 finish the frame, then fetch stops
    out_ready = 1'b0;
    grant_after(3);
    send(LW, 0, 300);
    wait_req();
    chk("t3_addr_row3", rd_mem_addr, 25'h0003000);
    grant_after(3);
    send(LW, 0, 400);
    tick(20);
    chk("t3_idle_busy", busy, 1'b0);
    chk("t3_idle_req", rd_mem_req, 1'b0);
    chk("t3_reqs", reqs, 4);
    chk("t4_frame", frame_cnt, 16'd1);
    out_ready = 1'b1;
    tick(LW);
    out_ready = 1'b0;
    wait_req();
    chk("t4_wrap_addr", rd_mem_addr, 25'h0000000);
    chk("t3_pops", pops, 24);
    chk("t4_eof_not_yet", eofs, 0);

    // 5: run_en dropped while waiting for grant
    out_ready = 1'b1;
    tick();
    run_en = 1'b0;
    grant_after(3);
    send(LW, 0, 500);
    tick(20);
    chk("t5_busy", busy, 1'b0);
    chk("t5_req", rd_mem_req, 1'b0);
    chk("t5_reqs", reqs, 5);
    chk("t5_pops", pops, 40);
    chk("t4_eof_seen", eofs, 1);

    // 6: asynchronous reset mid-transfer
    run_en = 1'b1;
    wait_req();
    chk("t6_addr_row1", rd_mem_addr, 25'h0001000);
    grant_after(2);
    send(5, 0, 600);
    @(posedge clk);
    #3 rst_n = 1'b0;
    run_en = 1'b0;
    #1;
    chk("t6_async_busy", busy, 1'b0);
    chk("t6_async_len", rd_xfr_len, 10'd0);
    chk("t6_async_valid", out_valid, 1'b0);
    chk("t6_async_frame", frame_cnt, 16'd0);
    tick(2);
    rst_n = 1'b1;
    tick();
    // valid while idle
    send(1, 0, 650);
    tick();
    chk("t6_extra", err_extra, 1'b1);
    chk("t6_ovf_clear", err_ovf, 1'b0);
    // first request after reset is row 0; one word arrives while FIFO is held full
    out_ready = 1'b0;
    run_en = 1'b1;
    wait_req();
    chk("t6_addr_row0", rd_mem_addr, 25'h0000000);
    run_en = 1'b0;
    grant_after(2);
    send(3, 0, 700);
    force_full = 1'b1;
    force dut.fill = 5'd16;
    dvld = 1'b1;
    dat  = 32'd703;
    tick();
    dvld = 1'b0;
    release dut.fill;
    force_full = 1'b0;
    send(4, 0, 704);
    tick(2);
    chk("t6_ovf", err_ovf, 1'b1);
    p0 = pops;
    out_ready = 1'b1;
    tick(20);
    chk("t6_kept_words", pops - p0, 7);
    chk("t6_end_busy", busy, 1'b0);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
